// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline types: inter-stage registers, LSU encodings and an alignment helper.
package rv32_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    WAIT_RD = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
  } ex_mem_pipeline_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        reg_write;
  } mem_wb_pipeline_reg_t;

  // Size encoding 2'b11 behaves as a word access.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] lsb);
    logic mis;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = lsb[0];
      default: mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding req/gnt/rvalid data-memory port; master is the pipeline side.
interface mem_stage_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane steering: store be/wdata generation and load extract/extend.
module mem_stage_lsu_align
  import rv32_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] lane;

  always_comb begin
    lane        = rdata_i >> {addr_lsb_i, 3'b000};
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = lane;
    case (size_i)
      MEM_B: begin
        be_o        = 4'b0001 << addr_lsb_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = unsigned_i ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      MEM_H: begin
        be_o        = 4'b0011 << addr_lsb_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = unsigned_i ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      end
      default: begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory port for one access at a time, stalls EX while it is
// in flight, and registers the MEM/WB pipeline register.
module mem_stage
  import rv32_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  ex_mem_pipeline_reg_t ex_mem_i,
  output mem_wb_pipeline_reg_t mem_wb_o,
  output logic                 stall_o,
  mem_stage_if.master          dmem,
  output logic                 misalign_o,
  output logic [31:0]          misalign_addr_o
);

  lsu_state_e           state_q, state_d;
  mem_wb_pipeline_reg_t mem_wb_q, mem_wb_d;
  logic                 misalign_q, misalign_d;
  logic [31:0]          misalign_addr_q, misalign_addr_d;

  logic        mem_op;
  logic        misaligned;
  logic        req;
  logic        done;
  logic        trap;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;

  assign mem_op     = ex_mem_i.valid & (ex_mem_i.mem_read | ex_mem_i.mem_write);
  assign misaligned = CHECK_ALIGN & is_misaligned(ex_mem_i.mem_size, ex_mem_i.result[1:0]);

  mem_stage_lsu_align u_align (
    .size_i       (ex_mem_i.mem_size),
    .unsigned_i   (ex_mem_i.mem_unsigned),
    .addr_lsb_i   (ex_mem_i.result[1:0]),
    .store_data_i (ex_mem_i.store_data),
    .rdata_i      (dmem.rdata),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    trap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            done = 1'b1;
            trap = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem.gnt) begin
              if (ex_mem_i.mem_write) done    = 1'b1;
              else                    state_d = WAIT_RD;
            end else begin
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem.gnt) begin
          if (ex_mem_i.mem_write) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (dmem.rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wb_d        = '0;
    misalign_d      = trap;
    misalign_addr_d = trap ? ex_mem_i.result : misalign_addr_q;
    if (ex_mem_i.valid && !mem_op) begin
      mem_wb_d.valid     = 1'b1;
      mem_wb_d.result    = ex_mem_i.result;
      mem_wb_d.rd_addr   = ex_mem_i.rd_addr;
      mem_wb_d.reg_write = ex_mem_i.reg_write;
    end else if (done) begin
      mem_wb_d.valid   = 1'b1;
      mem_wb_d.rd_addr = ex_mem_i.rd_addr;
      // Traps and stores never write the register file.
      if (trap || ex_mem_i.mem_write) begin
        mem_wb_d.result    = ex_mem_i.result;
        mem_wb_d.reg_write = 1'b0;
      end else begin
        mem_wb_d.result    = load_data;
        mem_wb_d.reg_write = ex_mem_i.reg_write;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      mem_wb_q        <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      mem_wb_q        <= mem_wb_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign stall_o         = mem_op & ~done;
  assign mem_wb_o        = mem_wb_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

  assign dmem.req   = req;
  assign dmem.we    = ex_mem_i.mem_write;
  assign dmem.be    = be;
  assign dmem.addr  = {ex_mem_i.result[31:2], 2'b00};
  assign dmem.wdata = wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads, misalignment and reset abort.
module tb_mem_stage;
  import rv32_pkg::*;

  logic                 clk;
  logic                 rst;
  ex_mem_pipeline_reg_t ex_mem;
  mem_wb_pipeline_reg_t mem_wb;
  logic                 stall;
  logic                 misalign;
  logic [31:0]          misalign_addr;

  int unsigned n_checks;
  int unsigned n_fail;

  mem_stage_if dmem_bus ();

  mem_stage #(
    .CHECK_ALIGN (1'b1)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_mem_i        (ex_mem),
    .mem_wb_o        (mem_wb),
    .stall_o         (stall),
    .dmem            (dmem_bus),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; combinational outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic set_mem(input logic rd, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd);
    ex_mem              = '0;
    ex_mem.valid        = 1'b1;
    ex_mem.result       = addr;
    ex_mem.store_data   = sd;
    ex_mem.rd_addr      = 5'd7;
    ex_mem.reg_write    = rd;
    ex_mem.mem_read     = rd;
    ex_mem.mem_write    = ~rd;
    ex_mem.mem_size     = size;
    ex_mem.mem_unsigned = uns;
  endtask

  task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    set_mem(1'b0, size, 1'b0, addr, sd);
    dmem_bus.gnt = 1'b1;
    mid();
    check_eq({tag, "_req"}, 32'(dmem_bus.req), 32'd1);
    check_eq({tag, "_be"}, 32'(dmem_bus.be), 32'(exp_be));
    check_eq({tag, "_wdata"}, dmem_bus.wdata, exp_wdata);
    check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    tick();
    dmem_bus.gnt = 1'b0;
    ex_mem       = '0;
    check_eq({tag, "_wb_valid"}, 32'(mem_wb.valid), 32'd1);
    check_eq({tag, "_wb_regw"}, 32'(mem_wb.reg_write), 32'd0);
  endtask

  // Grant in the first cycle, rvalid two cycles after the grant.
  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp_res);
    set_mem(1'b1, size, uns, addr, 32'h0);
    dmem_bus.gnt = 1'b1;
    mid();
    check_eq({tag, "_req"}, 32'(dmem_bus.req), 32'd1);
    check_eq({tag, "_addr"}, dmem_bus.addr, {addr[31:2], 2'b00});
    tick();
    dmem_bus.gnt = 1'b0;
    mid();
    check_eq({tag, "_wait_req"}, 32'(dmem_bus.req), 32'd0);
    check_eq({tag, "_wait_stall"}, 32'(stall), 32'd1);
    tick();
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = rdata;
    mid();
    check_eq({tag, "_done_stall"}, 32'(stall), 32'd0);
    tick();
    dmem_bus.rvalid = 1'b0;
    ex_mem          = '0;
    check_eq({tag, "_wb_valid"}, 32'(mem_wb.valid), 32'd1);
    check_eq({tag, "_wb_result"}, mem_wb.result, exp_res);
    check_eq({tag, "_wb_regw"}, 32'(mem_wb.reg_write), 32'd1);
    check_eq({tag, "_wb_rd"}, 32'(mem_wb.rd_addr), 32'd7);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    ex_mem          = '0;
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    mid();
    check_eq("rst_wb_valid", 32'(mem_wb.valid), 32'd0);
    check_eq("rst_wb_result", mem_wb.result, 32'h0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_misalign_addr", misalign_addr, 32'h0);
    check_eq("rst_req", 32'(dmem_bus.req), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    tick();

    // ALU op passes straight through with one cycle of latency.
    ex_mem           = '0;
    ex_mem.valid     = 1'b1;
    ex_mem.result    = 32'h1234;
    ex_mem.rd_addr   = 5'd5;
    ex_mem.reg_write = 1'b1;
    mid();
    check_eq("alu_stall", 32'(stall), 32'd0);
    check_eq("alu_req", 32'(dmem_bus.req), 32'd0);
    tick();
    ex_mem = '0;
    check_eq("alu_wb_valid", 32'(mem_wb.valid), 32'd1);
    check_eq("alu_wb_result", mem_wb.result, 32'h1234);
    check_eq("alu_wb_rd", 32'(mem_wb.rd_addr), 32'd5);
    check_eq("alu_wb_regw", 32'(mem_wb.reg_write), 32'd1);

    // SW with the grant held off for three cycles.
    set_mem(1'b0, 2'b10, 1'b0, 32'h100, 32'hAABBCCDD);
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("sw_hold_req", 32'(dmem_bus.req), 32'd1);
      check_eq("sw_hold_addr", dmem_bus.addr, 32'h100);
      check_eq("sw_hold_be", 32'(dmem_bus.be), 32'hF);
      check_eq("sw_hold_we", 32'(dmem_bus.we), 32'd1);
      check_eq("sw_hold_wdata", dmem_bus.wdata, 32'hAABBCCDD);
      check_eq("sw_hold_stall", 32'(stall), 32'd1);
      tick();
      check_eq("sw_bubble", 32'(mem_wb.valid), 32'd0);
    end
    dmem_bus.gnt = 1'b1;
    mid();
    check_eq("sw_gnt_req", 32'(dmem_bus.req), 32'd1);
    check_eq("sw_gnt_be", 32'(dmem_bus.be), 32'hF);
    check_eq("sw_gnt_stall", 32'(stall), 32'd0);
    tick();
    dmem_bus.gnt = 1'b0;
    ex_mem       = '0;
    check_eq("sw_wb_valid", 32'(mem_wb.valid), 32'd1);
    check_eq("sw_wb_regw", 32'(mem_wb.reg_write), 32'd0);

    do_store("sh", 2'b01, 32'h102, 32'h00001234, 4'b1100, 32'h12341234);
    do_store("sb", 2'b00, 32'h101, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);

    do_load("lb", 2'b00, 1'b0, 32'h103, 32'h80FF0000, 32'hFFFFFF80);
    do_load("lbu", 2'b00, 1'b1, 32'h103, 32'h80FF0000, 32'h00000080);
    do_load("lh", 2'b01, 1'b0, 32'h102, 32'h80010000, 32'hFFFF8001);
    do_load("lhu", 2'b01, 1'b1, 32'h102, 32'h80010000, 32'h00008001);
    do_load("lw", 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF);

    // Misaligned word load is trapped without a bus request.
    set_mem(1'b1, 2'b10, 1'b0, 32'h101, 32'h0);
    mid();
    check_eq("mis_req", 32'(dmem_bus.req), 32'd0);
    check_eq("mis_stall", 32'(stall), 32'd0);
    tick();
    ex_mem = '0;
    check_eq("mis_pulse", 32'(misalign), 32'd1);
    check_eq("mis_addr", misalign_addr, 32'h101);
    check_eq("mis_wb_valid", 32'(mem_wb.valid), 32'd1);
    check_eq("mis_wb_regw", 32'(mem_wb.reg_write), 32'd0);
    tick();
    check_eq("mis_pulse_end", 32'(misalign), 32'd0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    set_mem(1'b1, 2'b10, 1'b0, 32'h200, 32'h0);
    dmem_bus.gnt = 1'b1;
    tick();
    dmem_bus.gnt = 1'b0;
    mid();
    check_eq("rstrd_stall", 32'(stall), 32'd1);
    tick();
    rst    = 1'b1;
    ex_mem = '0;
    tick();
    rst             = 1'b0;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'h12345678;
    mid();
    check_eq("rstrd_req", 32'(dmem_bus.req), 32'd0);
    check_eq("rstrd_stall_after", 32'(stall), 32'd0);
    tick();
    dmem_bus.rvalid = 1'b0;
    check_eq("rstrd_wb_valid", 32'(mem_wb.valid), 32'd0);

    // A normal access afterwards proves the FSM returned to IDLE.
    do_store("post_rst_sw", 2'b10, 32'h300, 32'h0BADF00D, 4'b1111, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
